dp_bram_arbiter: RTL

// - Master side of the dp_bram_if dual-port BRAM interface. Connects through the arbiter modport.
// - Multiplexes NUM_CLIENTS request streams from the convolution engine clients onto the two BRAM ports:
//   - port A is read-only;
//   - port B is write-only.
// - Sustains 1 read + 1 write per cycle.
// - Resolves same-address read/write collisions and returns read data to the requesting client.

---
 rtl/conv_bram_pkg.sv | 15 +
 rtl/dp_bram_if.sv | 34 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/dp_bram_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/conv_bram_pkg.sv
// Shared types for the convolution-engine BRAM arbiter.
// Client ids are sized for up to 16 requesters.
package conv_bram_pkg;

  localparam int CLIENT_ID_W = 4;
  localparam int HAZ_CNT_W   = 16;

  typedef logic [CLIENT_ID_W-1:0] client_id_t;

  typedef struct packed {
    logic       valid;
    client_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/dp_bram_if.sv
// Dual-port BRAM bundle: port A read-only, port B write-only.
// The arbiter drives clock, reset and both address/control sets.
interface dp_bram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();

  logic                  clk;
  logic                  rst_n;
  logic                  en_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic [DATA_WIDTH-1:0] data_out_a;
  logic                  en_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;

  modport arbiter (
    output clk, rst_n,
    output en_a, we_a, addr_a, data_in_a,
    input  data_out_a,
    output en_b, we_b, addr_b, data_in_b
  );

  modport bram (
    input  clk, rst_n,
    input  en_a, we_a, addr_a, data_in_a,
    output data_out_a,
    input  en_b, we_b, addr_b, data_in_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// The pointer register belongs to the caller.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_id          = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dp_bram_arbiter.sv
// Multiplexes client reads onto BRAM port A and writes onto port B.
// Same-address read/write in one cycle: write wins, read retries.
module dp_bram_arbiter
  import conv_bram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_CLIENTS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_CLIENTS-1:0]                  req_valid,
  output logic [NUM_CLIENTS-1:0]                  req_ready,
  input  logic [NUM_CLIENTS-1:0]                  req_we,
  input  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_CLIENTS-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]                   rsp_data,
  output logic [HAZ_CNT_W-1:0]                    hazard_cnt,
  dp_bram_if.arbiter                              bram
);

  localparam int ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [NUM_CLIENTS-1:0] rd_req, wr_req;
  logic [NUM_CLIENTS-1:0] rd_oh, wr_oh;
  logic [ID_W-1:0]        rd_ptr, wr_ptr;
  logic [ID_W-1:0]        rd_id, wr_id;
  logic [ID_W-1:0]        rd_nxt, wr_nxt;
  logic                   rd_any, wr_any;
  logic                   collide, rd_go, wr_go;
  rd_tag_t                tag;

  assign rd_req = req_valid & ~req_we;
  assign wr_req = req_valid & req_we;

  rr_arbiter #(.N(NUM_CLIENTS), .ID_W(ID_W)) u_rd_arb (
    .req        (rd_req),
    .ptr        (rd_ptr),
    .gnt_onehot (rd_oh),
    .gnt_id     (rd_id),
    .any        (rd_any)
  );

  rr_arbiter #(.N(NUM_CLIENTS), .ID_W(ID_W)) u_wr_arb (
    .req        (wr_req),
    .ptr        (wr_ptr),
    .gnt_onehot (wr_oh),
    .gnt_id     (wr_id),
    .any        (wr_any)
  );

  assign collide = rd_any && wr_any && !rst
                && (req_addr[rd_id] == req_addr[wr_id]);
  assign rd_go   = rd_any && !collide && !rst;
  assign wr_go   = wr_any && !rst;

  assign req_ready = ({NUM_CLIENTS{rd_go}} & rd_oh)
                   | ({NUM_CLIENTS{wr_go}} & wr_oh);

  assign rd_nxt = ID_W'((int'(rd_id) + 1) % NUM_CLIENTS);
  assign wr_nxt = ID_W'((int'(wr_id) + 1) % NUM_CLIENTS);

  assign bram.clk       = clk;
  assign bram.rst_n     = ~rst;
  assign bram.en_a      = rd_go;
  assign bram.we_a      = 1'b0;
  assign bram.addr_a    = req_addr[rd_id];
  assign bram.data_in_a = '0;
  assign bram.en_b      = wr_go;
  assign bram.we_b      = wr_go;
  assign bram.addr_b    = req_addr[wr_id];
  assign bram.data_in_b = req_wdata[wr_id];

  // tag tracks the read whose data appears on data_out_a next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      hazard_cnt <= '0;
    end else begin
      if (rd_go) rd_ptr <= rd_nxt;
      if (wr_go) wr_ptr <= wr_nxt;
      tag.valid <= rd_go;
      tag.id    <= client_id_t'(rd_id);
      rsp_valid <= tag.valid ? (NUM_CLIENTS'(1) << tag.id) : '0;
      if (tag.valid) rsp_data <= bram.data_out_a;
      if (collide && hazard_cnt != '1)
        hazard_cnt <= hazard_cnt + HAZ_CNT_W'(1);
    end
  end

endmodule
